// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// State encoding, counter widths and one-hot decode.
package fifo_arb_pkg;

    localparam int ST_W   = 2;
    localparam int BCNT_W = 8;
    localparam int IDX_W  = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE       = 2'd0,
        ST_SETUP      = 2'd1,
        ST_BURST      = 2'd2,
        ST_WAIT_DRAIN = 2'd3
    } state_e;

    // Up to four requesters; callers zero-extend narrower grant vectors.
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [3:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational winner select for the write arbiter.
// Round robin from rr_ptr by default; FIFO_ARB_FIXED_PRIO_EN selects lowest-index-wins.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    logic found;

    assign any = |req;

`ifdef FIFO_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (!found && req[c]) begin
                winner = IDX_W'(c);
                found  = 1'b1;
            end
        end
    end
`else
    // Scan distance k from the pointer; constant inner index keeps selects static.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int c = 0; c < NUM_REQ; c++) begin
                if (!found && req[c] && (c == (int'(rr_ptr) + k) % NUM_REQ)) begin
                    winner = IDX_W'(c);
                    found  = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the single FIFO write port between NUM_REQ producers with burst framing
// and almost_full/almost_empty flow control. FIFO_ARB_FIXED_PRIO_EN selects fixed priority.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        wr_ack,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      almost_full,
    input  logic                      almost_empty,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wdata,
    output logic                      busy
);

    localparam logic [BCNT_W-1:0] BMAX = BCNT_W'(BURST_MAX);

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d, bcnt_inc;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d, next_ptr, g, winner;
    logic                any, req_g, xfer;
    logic [DATA_W-1:0]   wsel;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign g        = onehot2idx(4'(gnt_q));
    assign req_g    = |(req & gnt_q);
    assign xfer     = (state_q == ST_BURST) && req_g && !almost_full && (bcnt_q < BMAX);
    assign wr_ack   = xfer ? gnt_q : '0;
    assign bcnt_inc = (bcnt_q == '1) ? bcnt_q : bcnt_q + 1'b1;

`ifdef FIFO_ARB_FIXED_PRIO_EN
    assign next_ptr = '0;
`else
    assign next_ptr = (g == IDX_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
`endif

    always_comb begin
        wsel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) wsel = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        wr_en_d  = 1'b0;
        wdata_d  = wdata_q;
        bcnt_d   = bcnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (any && !almost_full) begin
                    gnt_d   = NUM_REQ'(1) << winner;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_BURST;
            ST_BURST: begin
                if (xfer) begin
                    wr_en_d = 1'b1;
                    wdata_d = wsel;
                    bcnt_d  = bcnt_inc;
                end
                // almost_full takes precedence over a dropped request or a full burst
                if (almost_full || !req_g || (xfer && bcnt_inc >= BMAX)) begin
                    state_d  = almost_full ? ST_WAIT_DRAIN : ST_IDLE;
                    gnt_d    = '0;
                    bcnt_d   = '0;
                    rr_ptr_d = next_ptr;
                end
            end
            ST_WAIT_DRAIN: begin
                if (almost_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            wr_en_q  <= 1'b0;
            wdata_q  <= '0;
            bcnt_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            wr_en_q  <= wr_en_d;
            wdata_q  <= wdata_d;
            bcnt_q   <= bcnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign gnt        = gnt_q;
    assign fifo_wr_en = wr_en_q;
    assign fifo_wdata = wdata_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scenarios plus randomized traffic for fifo_wr_arbiter, checked against a
// transaction-level scoreboard (transfer -> write one cycle later, grant choice, burst length).
module tb_fifo_wr_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int BM = 16;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    wr_ack, gnt;
    logic            almost_full = 1'b0, almost_empty = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wdata;
    logic            busy;

    int total = 0, bad = 0;
    int dcnt [N];
    int cyc = 0, c0 = 0, nb = 0;
    int wcyc [$];
    int wdat [$];
    int rlen [$];
    int rsrc [$];

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req          (req),
        .req_wdata    (req_wdata),
        .wr_ack       (wr_ack),
        .gnt          (gnt),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wdata   (fifo_wdata),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Producer i presents word i*64 + (words already sent, mod 64).
    always_comb begin
        req_wdata = '0;
        for (int i = 0; i < N; i++) req_wdata[i*DW +: DW] = DW'(i*64 + dcnt[i] % 64);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: producers pop on handshake, writes are logged after the edge.
    task automatic tick();
        logic [N-1:0] xf;
        #1;
        xf = req & wr_ack;
        @(posedge sys_clk);
        #2;
        cyc++;
        for (int i = 0; i < N; i++) if (xf[i]) dcnt[i]++;
        if (fifo_wr_en) begin
            wcyc.push_back(cyc);
            wdat.push_back(int'(fifo_wdata));
        end
    endtask

    task automatic do_reset();
        sys_rst_n    = 1'b0;
        req          = '0;
        almost_full  = 1'b0;
        almost_empty = 1'b0;
        for (int i = 0; i < N; i++) dcnt[i] = 0;
        repeat (2) tick();
        sys_rst_n = 1'b1;
        wcyc.delete();
        wdat.delete();
        c0 = cyc;
    endtask

    function automatic logic [N-1:0] exp_pick(input logic [N-1:0] r, input int last);
`ifdef FIFO_ARB_FIXED_PRIO_EN
        for (int c = 0; c < N; c++) if (r[c]) return N'(1) << c;
`else
        for (int k = 0; k < N; k++) if (r[(last + 1 + k) % N]) return N'(1) << ((last + 1 + k) % N);
`endif
        return '0;
    endfunction

    // Scoreboard sampled mid-cycle, when inputs and registered outputs are stable.
    logic [N-1:0]  m_prev_req = '0, m_prev_gnt = '0, m_xf;
    logic          m_prev_af = 1'b0, m_exp_wr = 1'b0;
    logic [DW-1:0] m_exp_d = '0;
    int            m_last = N - 1, m_blen = 0;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            m_exp_wr = 1'b0;
            m_last   = N - 1;
            m_blen   = 0;
        end else begin
            chk("mon_wr_en", 32'(fifo_wr_en), 32'(m_exp_wr));
            if (m_exp_wr) chk("mon_wdata", 32'(fifo_wdata), 32'(m_exp_d));
            chk("mon_gnt_onehot", 32'($onehot0(gnt)), 1);
            chk("mon_ack_in_gnt", 32'(wr_ack & ~gnt), 0);
            if (almost_full) chk("mon_ack_af", 32'(wr_ack), 0);
            if (gnt != '0 && m_prev_gnt == '0) begin
                chk("mon_gnt_af", 32'(m_prev_af), 0);
                chk("mon_gnt_pick", 32'(gnt), 32'(exp_pick(m_prev_req, m_last)));
                m_blen = 0;
            end
            m_xf     = req & wr_ack;
            m_exp_wr = |m_xf;
            for (int i = 0; i < N; i++) if (m_xf[i]) m_exp_d = req_wdata[i*DW +: DW];
            if (m_exp_wr) begin
                m_blen++;
                chk("mon_burst_len", 32'(m_blen <= BM), 1);
            end
            for (int i = 0; i < N; i++) if (gnt[i]) m_last = i;
        end
        m_prev_gnt = gnt;
        m_prev_req = req;
        m_prev_af  = almost_full;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with requests already pending.
        #1 sys_rst_n = 1'b0;
        req = '1;
        #2;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_wdata", 32'(fifo_wdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_ack", 32'(wr_ack), 0);
        repeat (2) tick();
        chk("rst_gnt_clk", 32'(gnt), 0);
        chk("rst_wr_ack_clk", 32'(wr_ack), 0);

        // Lone requester: 16-word bursts, two dead cycles between them.
        do_reset();
        req = 2'b01;
        repeat (40) tick();
        chk("s1_nwords", 32'(wdat.size() >= 32), 1);
        if (wcyc.size() > 0) chk("s1_first_lat", 32'(wcyc[0] - c0), 3);
        for (int k = 0; k < 32 && k < wdat.size(); k++) begin
            chk("s1_data", 32'(wdat[k]), 32'(k));
            if (k > 0) chk("s1_spacing", 32'(wcyc[k] - wcyc[k-1]), (k == 16) ? 3 : 1);
        end

        // Two requesters always asking: alternating 16-word bursts.
        do_reset();
        req = 2'b11;
        repeat (80) tick();
        rlen.delete();
        rsrc.delete();
        for (int k = 0; k < wdat.size(); k++) begin
            if (k == 0 || wcyc[k] != wcyc[k-1] + 1) begin
                rlen.push_back(0);
                rsrc.push_back(wdat[k] / 64);
            end
            rlen[rlen.size()-1] = rlen[rlen.size()-1] + 1;
        end
        chk("s2_nbursts", 32'(rlen.size() >= 4), 1);
        for (int r = 0; r < 4 && r < rlen.size(); r++) begin
            chk("s2_burst_len", 32'(rlen[r]), BM);
`ifdef FIFO_ARB_FIXED_PRIO_EN
            chk("s2_burst_src", 32'(rsrc[r]), 0);
`else
            chk("s2_burst_src", 32'(rsrc[r]), 32'(r % 2));
`endif
        end

        // almost_full after word 5, drain handshake, almost_full held in IDLE.
        do_reset();
        req = 2'b01;
        for (int t = 0; t < 60 && dcnt[0] != 5; t++) tick();
        chk("s3_reach5", 32'(dcnt[0]), 5);
        almost_full = 1'b1;
        #1 chk("s3_ack_drop", 32'(wr_ack), 0);
        nb = wdat.size();
        repeat (10) tick();
        chk("s3_extra_writes", 32'(wdat.size() - nb <= 1), 1);
        chk("s3_nwords", 32'(wdat.size()), 5);
        chk("s3_drain_busy", 32'(busy), 1);
        chk("s3_drain_gnt", 32'(gnt), 0);
        almost_empty = 1'b1;
        tick();
        chk("s3_ae_wins", 32'(busy), 0);
        almost_empty = 1'b0;
        repeat (4) tick();
        chk("s6_af_idle_gnt", 32'(gnt), 0);
        chk("s6_af_idle_busy", 32'(busy), 0);
        almost_full = 1'b0;
        tick();
        chk("s3_regrant", 32'(gnt), 32'(2'b01));
        repeat (2) tick();
        chk("s3_resume_n", 32'(wdat.size()), 6);
        if (wdat.size() > 5) chk("s3_resume_data", 32'(wdat[5]), 5);

        // Requester 1 drops after 3 words.
        do_reset();
        req = 2'b10;
        for (int t = 0; t < 40 && dcnt[1] != 3; t++) tick();
        chk("s4_reach3", 32'(dcnt[1]), 3);
        req = 2'b00;
        #1 chk("s4_ack_drop", 32'(wr_ack), 0);
        tick();
        chk("s4_gnt_off", 32'(gnt), 0);
        chk("s4_idle", 32'(busy), 0);
        req = 2'b11;
        tick();
        chk("s4_next_gnt", 32'(gnt), 32'(2'b01));

        // Asynchronous reset on word 7.
        do_reset();
        req = 2'b01;
        for (int t = 0; t < 40 && dcnt[0] != 7; t++) tick();
        chk("s5_reach7", 32'(dcnt[0]), 7);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("s5_async_gnt", 32'(gnt), 0);
        chk("s5_async_wr_en", 32'(fifo_wr_en), 0);
        chk("s5_async_ack", 32'(wr_ack), 0);
        chk("s5_async_busy", 32'(busy), 0);
        nb = wdat.size();
        repeat (2) tick();
        chk("s5_no_writes", 32'(wdat.size()), 32'(nb));
        sys_rst_n = 1'b1;
        tick();
        chk("s5_setup_busy", 32'(busy), 1);
        chk("s5_wr_en_a", 32'(fifo_wr_en), 0);
        tick();
        chk("s5_wr_en_b", 32'(fifo_wr_en), 0);
        tick();
        chk("s5_wr_en_c", 32'(fifo_wr_en), 1);
        chk("s5_wdata_c", 32'(fifo_wdata), 7);

        // Randomized traffic, checked by the scoreboard.
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
            if (almost_full) almost_full = ($urandom_range(3) != 0);
            else             almost_full = ($urandom_range(31) == 0);
            almost_empty = ($urandom_range(3) == 0);
            tick();
        end
        chk("rnd_progress", 32'(wdat.size() > 100), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
